// File: rtl/mem_access_sequencer_pkg.sv
// Shared state type, load-type encodings and size/alignment helpers for mem_access_sequencer.
package mem_access_sequencer_pkg;

  localparam logic [2:0] BYTE_MASK  = 3'b001;
  localparam logic [2:0] HWORD_MASK = 3'b011;
  localparam logic [2:0] WORD_MASK  = 3'b111;

  typedef enum logic [2:0] {
    IDLE,
    ACCESS,
    COLLECT,
    RESP,
    FAULT
  } seq_state_t;

  // Unknown encodings are treated as full words so they never split into partial lanes.
  function automatic logic [2:0] size_of(input logic [2:0] load_type);
    case (load_type)
      BYTE_MASK:  size_of = 3'd1;
      HWORD_MASK: size_of = 3'd2;
      WORD_MASK:  size_of = 3'd4;
      default:    size_of = 3'd4;
    endcase
  endfunction

  function automatic logic misaligned(input logic [1:0] addr_lo, input logic [2:0] load_type);
    case (size_of(load_type))
      3'd2:    misaligned = addr_lo[0];
      3'd4:    misaligned = |addr_lo;
      default: misaligned = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/mem_access_sequencer_if.sv
// Request/response and data-memory signal bundle; slave = sequencer side, master = pipeline/memory side.
// misalign_fault is present only when MISALIGN_TRAP_EN is defined.
interface mem_access_sequencer_if #(
  parameter int ADDR_W = 32,
  parameter int TAG_W  = 5
);
  logic              req_valid;
  logic              req_ready;
  logic              req_read;
  logic              req_write;
  logic [ADDR_W-1:0] req_addr;
  logic [31:0]       req_wdata;
  logic [2:0]        req_load_type;
  logic              req_sign_extend;
  logic [TAG_W-1:0]  req_tag;

  logic              rsp_valid;
  logic [31:0]       rsp_data;
  logic [TAG_W-1:0]  rsp_tag;
`ifdef MISALIGN_TRAP_EN
  logic              misalign_fault;
`endif

  logic              mem_read;
  logic              mem_write;
  logic [31:0]       mem_long_addr;
  logic [31:0]       mem_write_value;
  logic [2:0]        mem_load_type;
  logic              mem_sign_extend;
  logic [31:0]       mem_read_value;

  modport slave (
    input  req_valid, req_read, req_write, req_addr, req_wdata, req_load_type,
           req_sign_extend, req_tag, mem_read_value,
    output req_ready, rsp_valid, rsp_data, rsp_tag,
`ifdef MISALIGN_TRAP_EN
           misalign_fault,
`endif
           mem_read, mem_write, mem_long_addr, mem_write_value, mem_load_type, mem_sign_extend
  );

  modport master (
    output req_valid, req_read, req_write, req_addr, req_wdata, req_load_type,
           req_sign_extend, req_tag, mem_read_value,
    input  req_ready, rsp_valid, rsp_data, rsp_tag,
`ifdef MISALIGN_TRAP_EN
           misalign_fault,
`endif
           mem_read, mem_write, mem_long_addr, mem_write_value, mem_load_type, mem_sign_extend
  );

endinterface

// File: rtl/mem_access_sequencer_load_assembler.sv
// Combinational merge of the low i_size byte lanes with sign/zero fill above them; no state, no backpressure.
module mem_access_sequencer_load_assembler #(
  parameter int MAX_BYTES = 4
) (
  input  logic [MAX_BYTES-1:0][7:0]     i_lanes,
  input  logic [$clog2(MAX_BYTES):0]    i_size,
  input  logic                          i_sign_ext,
  output logic [8*MAX_BYTES-1:0]        o_data
);

  logic w_msb;

  always_comb begin
    w_msb  = 1'b0;
    o_data = '0;
    for (int b = 0; b < MAX_BYTES; b++) begin
      if (b < int'(i_size)) begin
        o_data[8*b +: 8] = i_lanes[b];
        w_msb            = i_lanes[b][7];
      end else begin
        o_data[8*b +: 8] = {8{i_sign_ext & w_msb}};
      end
    end
  end

endmodule

// File: rtl/mem_access_sequencer.sv
// Serialises one load/store at a time into data_memory_top; aligned load responds 3 cycles after accept, split k-byte load k+2.
// req_ready is high only in IDLE (no overlap). MISALIGN_TRAP_EN: misaligned requests fault instead of splitting.
module mem_access_sequencer
  import mem_access_sequencer_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int TAG_W  = 5
) (
  input logic                   clock,
  input logic                   reset_n,
  mem_access_sequencer_if.slave bus
);

  seq_state_t r_state;
  seq_state_t w_state_nxt;

  logic              r_is_load;
  logic              r_aligned;
  logic [ADDR_W-1:0] r_addr;
  logic [31:0]       r_wdata;
  logic [2:0]        r_load_type;
  logic              r_sign_ext;
  logic [TAG_W-1:0]  r_tag;
  logic [2:0]        r_idx;
  logic [2:0]        r_n;
  logic [3:0][7:0]   r_lanes;
  logic [31:0]       r_rsp_data;
  logic [TAG_W-1:0]  r_rsp_tag;

  logic              w_accept;
  logic              w_valid_op;
  logic              w_req_mis;
  logic [1:0]        w_prev_lane;
  logic [1:0]        w_cur_lane;
  logic [3:0][7:0]   w_lanes;
  logic [31:0]       w_asm_data;
  logic [31:0]       w_collect_data;

  logic              w_mem_read;
  logic              w_mem_write;
  logic [ADDR_W-1:0] w_mem_addr;
  logic [31:0]       w_mem_wval;
  logic [2:0]        w_mem_lt;
  logic              w_mem_se;

  assign w_accept    = (r_state == IDLE) && bus.req_valid;
  assign w_valid_op  = bus.req_read ^ bus.req_write;
  assign w_req_mis   = misaligned(bus.req_addr[1:0], bus.req_load_type);
  assign w_prev_lane = 2'(r_idx - 3'd1);
  assign w_cur_lane  = r_idx[1:0];

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      IDLE: begin
        if (w_accept && w_valid_op) begin
`ifdef MISALIGN_TRAP_EN
          w_state_nxt = w_req_mis ? FAULT : ACCESS;
`else
          w_state_nxt = ACCESS;
`endif
        end
      end
      ACCESS: begin
        if (r_idx == r_n - 3'd1) begin
          w_state_nxt = r_is_load ? COLLECT : IDLE;
        end
      end
      COLLECT: w_state_nxt = RESP;
      RESP:    w_state_nxt = IDLE;
      FAULT:   w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // Memory controls decode from latched request state; everything is zero outside ACCESS.
  always_comb begin
    w_mem_read  = 1'b0;
    w_mem_write = 1'b0;
    w_mem_addr  = '0;
    w_mem_wval  = 32'h0;
    w_mem_lt    = 3'b000;
    w_mem_se    = 1'b0;
    if (r_state == ACCESS) begin
      w_mem_read  = r_is_load;
      w_mem_write = !r_is_load;
      if (r_aligned) begin
        w_mem_addr = r_addr;
        w_mem_wval = r_wdata;
        w_mem_lt   = r_load_type;
        w_mem_se   = r_sign_ext;
      end else begin
        w_mem_addr = r_addr + ADDR_W'(r_idx);
        w_mem_wval = {24'h0, r_wdata[{w_cur_lane, 3'b000} +: 8]};
        w_mem_lt   = BYTE_MASK;
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_is_load   <= 1'b0;
      r_aligned   <= 1'b0;
      r_addr      <= '0;
      r_wdata     <= 32'h0;
      r_load_type <= 3'b000;
      r_sign_ext  <= 1'b0;
      r_tag       <= '0;
      r_idx       <= 3'd0;
      r_n         <= 3'd0;
      r_lanes     <= '0;
      r_rsp_data  <= 32'h0;
      r_rsp_tag   <= '0;
    end else begin
      if (w_accept) begin
        r_is_load   <= bus.req_read;
        r_aligned   <= !w_req_mis;
        r_addr      <= bus.req_addr;
        r_wdata     <= bus.req_wdata;
        r_load_type <= bus.req_load_type;
        r_sign_ext  <= bus.req_sign_extend;
        r_tag       <= bus.req_tag;
        r_idx       <= 3'd0;
        r_n         <= w_req_mis ? size_of(bus.req_load_type) : 3'd1;
      end else if (r_state == ACCESS) begin
        r_idx <= r_idx + 3'd1;
        // Read data trails the strobe by one cycle, so this is the previous element's byte.
        if (r_is_load && r_idx != 3'd0) begin
          r_lanes[w_prev_lane] <= bus.mem_read_value[7:0];
        end
      end
      if (r_state == COLLECT) begin
        r_rsp_data <= w_collect_data;
        r_rsp_tag  <= r_tag;
      end
`ifdef MISALIGN_TRAP_EN
      if (w_accept && w_valid_op && w_req_mis) begin
        r_rsp_tag <= bus.req_tag;
      end
`endif
    end
  end

  always_comb begin
    w_lanes              = r_lanes;
    w_lanes[w_prev_lane] = bus.mem_read_value[7:0];
  end

  mem_access_sequencer_load_assembler #(
    .MAX_BYTES(4)
  ) u_load_assembler (
    .i_lanes   (w_lanes),
    .i_size    (r_n),
    .i_sign_ext(r_sign_ext),
    .o_data    (w_asm_data)
  );

  assign w_collect_data = r_aligned ? bus.mem_read_value : w_asm_data;

  assign bus.req_ready       = (r_state == IDLE);
  assign bus.rsp_valid       = (r_state == RESP);
  assign bus.rsp_data        = r_rsp_data;
  assign bus.rsp_tag         = r_rsp_tag;
`ifdef MISALIGN_TRAP_EN
  assign bus.misalign_fault  = (r_state == FAULT);
`endif
  assign bus.mem_read        = w_mem_read;
  assign bus.mem_write       = w_mem_write;
  assign bus.mem_long_addr   = 32'(w_mem_addr);
  assign bus.mem_write_value = w_mem_wval;
  assign bus.mem_load_type   = w_mem_lt;
  assign bus.mem_sign_extend = w_mem_se;

endmodule

// File: tb/tb_mem_access_sequencer.sv
// Scoreboard bench for mem_access_sequencer: byte-array memory on the DUT side, independent byte-array reference model.
module tb_mem_access_sequencer;
  import mem_access_sequencer_pkg::*;

  typedef struct packed {
    logic [31:0] cyc;
    logic        rd;
    logic        wr;
    logic [31:0] addr;
    logic [2:0]  lt;
    logic        se;
    logic [31:0] wv;
  } op_t;

  typedef struct packed {
    logic [31:0] cyc;
    logic [31:0] data;
    logic [4:0]  tag;
  } rsp_t;

  typedef struct packed {
    logic [31:0] cyc;
    logic [4:0]  tag;
  } flt_t;

  logic        clock   = 1'b0;
  logic        reset_n = 1'b0;
  logic [31:0] cyc     = 32'h0;
  int          n_cmp   = 0;
  int          n_bad   = 0;

  op_t  exp_ops[$];
  rsp_t exp_rsp[$];
  flt_t exp_flt[$];
  bit [7:0] dmem [bit [31:0]];
  bit [7:0] refm [bit [31:0]];

  logic [31:0] last_rsp     = 32'h0;
  logic [4:0]  last_flt_tag = 5'h0;
  op_t  mon_op, mon_exp_op;
  rsp_t mon_rsp, mon_exp_rsp;
  flt_t mon_flt, mon_exp_flt;

  mem_access_sequencer_if #(.ADDR_W(32), .TAG_W(5)) bus ();

  mem_access_sequencer #(.ADDR_W(32), .TAG_W(5)) dut (
    .clock  (clock),
    .reset_n(reset_n),
    .bus    (bus)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 32'd1;

  task automatic check(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic int size_b(input logic [2:0] lt);
    if (lt == BYTE_MASK)  return 1;
    if (lt == HWORD_MASK) return 2;
    return 4;
  endfunction

  function automatic logic [31:0] extend(input logic [31:0] v, input int sz, input logic se);
    logic [31:0] r;
    r = v;
    if (sz == 1) r[31:8] = se ? {24{v[7]}} : 24'h0;
    else if (sz == 2) r[31:16] = se ? {16{v[15]}} : 16'h0;
    return r;
  endfunction

  function automatic logic [7:0] dmem_rd(input logic [31:0] a);
    return dmem.exists(a) ? dmem[a] : 8'h00;
  endfunction

  function automatic logic [7:0] refm_rd(input logic [31:0] a);
    return refm.exists(a) ? refm[a] : 8'h00;
  endfunction

  // Behaves like data_memory_top: access sampled in one cycle, read data presented in the next.
  initial begin : mem_model
    logic rd, wr, se;
    logic [31:0] a, wv, v;
    logic [2:0] lt;
    bus.mem_read_value = 32'h0;
    forever begin
      @(negedge clock);
      rd = bus.mem_read;  wr = bus.mem_write;  a  = bus.mem_long_addr;
      wv = bus.mem_write_value;  lt = bus.mem_load_type;  se = bus.mem_sign_extend;
      @(posedge clock);
      #1;
      if (wr) for (int i = 0; i < size_b(lt); i++) dmem[a + 32'(i)] = wv[8*i +: 8];
      if (rd) begin
        v = 32'h0;
        for (int i = 0; i < size_b(lt); i++) v[8*i +: 8] = dmem_rd(a + 32'(i));
        bus.mem_read_value = extend(v, size_b(lt), se);
      end else begin
        bus.mem_read_value = $urandom;
      end
    end
  end

  always @(negedge clock) begin
    if (reset_n) begin
      if (bus.mem_read || bus.mem_write) begin
        mon_op = '{cyc: cyc, rd: bus.mem_read, wr: bus.mem_write, addr: bus.mem_long_addr,
                   lt: bus.mem_load_type, se: bus.mem_sign_extend,
                   wv: bus.mem_write ? bus.mem_write_value : 32'h0};
        if (exp_ops.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL unexpected_memop: got %h expected none", mon_op);
        end else begin
          mon_exp_op = exp_ops.pop_front();
          check("memop", 128'(mon_op), 128'(mon_exp_op));
        end
      end
      if (bus.rsp_valid) begin
        mon_rsp  = '{cyc: cyc, data: bus.rsp_data, tag: bus.rsp_tag};
        last_rsp = bus.rsp_data;
        if (exp_rsp.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL unexpected_rsp: got %h expected none", mon_rsp);
        end else begin
          mon_exp_rsp = exp_rsp.pop_front();
          check("rsp", 128'(mon_rsp), 128'(mon_exp_rsp));
        end
      end
`ifdef MISALIGN_TRAP_EN
      if (bus.misalign_fault) begin
        mon_flt      = '{cyc: cyc, tag: bus.rsp_tag};
        last_flt_tag = bus.rsp_tag;
        if (exp_flt.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL unexpected_fault: got %h expected none", mon_flt);
        end else begin
          mon_exp_flt = exp_flt.pop_front();
          check("fault", 128'(mon_flt), 128'(mon_exp_flt));
        end
      end
`endif
    end
  end

  // Drive one request and queue everything the reference model says it must produce.
  task automatic issue(input logic rd, input logic wr, input logic [31:0] addr, input logic [2:0] lt,
                       input logic se, input logic [4:0] tag, input logic [31:0] wdata);
    int g, sz, k;
    logic mis;
    logic [31:0] n, v;
    op_t o;
    rsp_t r;
    @(negedge clock);
    bus.req_valid = 1'b1;  bus.req_read = rd;  bus.req_write = wr;  bus.req_addr = addr;
    bus.req_load_type = lt;  bus.req_sign_extend = se;  bus.req_tag = tag;  bus.req_wdata = wdata;
    g = 0;
    while (!bus.req_ready && g < 20) begin
      @(negedge clock);
      g++;
    end
    if (!bus.req_ready) begin
      n_cmp++; n_bad++;
      $display("FAIL req_ready_timeout: got 0 expected 1");
    end
    n = cyc;
    if (rd ^ wr) begin
      sz  = size_b(lt);
      mis = (addr % 32'(sz)) != 32'h0;
`ifdef MISALIGN_TRAP_EN
      if (mis) exp_flt.push_back('{cyc: n + 32'd1, tag: tag});
      else
`endif
      begin
        k = mis ? sz : 1;
        for (int i = 0; i < k; i++) begin
          o.cyc  = n + 32'd1 + 32'(i);
          o.rd   = rd;
          o.wr   = wr;
          o.addr = mis ? addr + 32'(i) : addr;
          o.lt   = mis ? BYTE_MASK : lt;
          o.se   = mis ? 1'b0 : se;
          o.wv   = !wr ? 32'h0 : (mis ? {24'h0, wdata[8*i +: 8]} : wdata);
          exp_ops.push_back(o);
        end
        if (wr) begin
          for (int i = 0; i < sz; i++) refm[addr + 32'(i)] = wdata[8*i +: 8];
        end else begin
          v = 32'h0;
          for (int i = 0; i < sz; i++) v[8*i +: 8] = refm_rd(addr + 32'(i));
          r = '{cyc: n + 32'(mis ? sz + 2 : 3), data: extend(v, sz, se), tag: tag};
          exp_rsp.push_back(r);
        end
      end
    end
    @(posedge clock);
    #1;
    bus.req_valid = 1'b0;
  endtask

  task automatic drain();
    int g;
    g = 0;
    while ((exp_ops.size() != 0 || exp_rsp.size() != 0 || exp_flt.size() != 0 || !bus.req_ready) && g < 40) begin
      @(negedge clock);
      g++;
    end
    if (g >= 40) begin
      n_cmp++; n_bad++;
      $display("FAIL drain_timeout: got %0d pending expected 0", exp_ops.size() + exp_rsp.size() + exp_flt.size());
    end
    @(negedge clock);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got time limit expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [2:0] lts [3];
    int r;
    logic rd, wr;
    logic [31:0] a;
    lts[0] = BYTE_MASK;  lts[1] = HWORD_MASK;  lts[2] = WORD_MASK;
    bus.req_valid = 1'b0;  bus.req_read = 1'b0;  bus.req_write = 1'b0;  bus.req_addr = 32'h0;
    bus.req_wdata = 32'h0;  bus.req_load_type = 3'b000;  bus.req_sign_extend = 1'b0;  bus.req_tag = 5'h0;

    repeat (2) @(negedge clock);
    check("rst_req_ready", 128'(bus.req_ready), 128'(1));
    check("rst_rsp_valid", 128'(bus.rsp_valid), 128'(0));
    check("rst_mem_read", 128'(bus.mem_read), 128'(0));
    check("rst_mem_write", 128'(bus.mem_write), 128'(0));
    check("rst_mem_addr", 128'(bus.mem_long_addr), 128'(0));
    check("rst_mem_wval", 128'(bus.mem_write_value), 128'(0));
    check("rst_mem_lt", 128'(bus.mem_load_type), 128'(0));
    check("rst_mem_se", 128'(bus.mem_sign_extend), 128'(0));
    check("rst_rsp_data", 128'(bus.rsp_data), 128'(0));
    check("rst_rsp_tag", 128'(bus.rsp_tag), 128'(0));
`ifdef MISALIGN_TRAP_EN
    check("rst_fault", 128'(bus.misalign_fault), 128'(0));
`endif
    reset_n = 1'b1;

    issue(1'b0, 1'b1, 32'h10, WORD_MASK, 1'b0, 5'd1, 32'hDEADBEEF);
    issue(1'b1, 1'b0, 32'h10, WORD_MASK, 1'b0, 5'd2, 32'h0);
    drain();
    check("word_load", 128'(last_rsp), 128'(32'hDEADBEEF));
    issue(1'b0, 1'b1, 32'h3, BYTE_MASK, 1'b0, 5'd3, 32'h80);
    issue(1'b1, 1'b0, 32'h3, BYTE_MASK, 1'b1, 5'd4, 32'h0);
    drain();
    check("byte_sext", 128'(last_rsp), 128'(32'hFFFFFF80));
    issue(1'b1, 1'b0, 32'h3, BYTE_MASK, 1'b0, 5'd5, 32'h0);
    drain();
    check("byte_zext", 128'(last_rsp), 128'(32'h00000080));
    issue(1'b0, 1'b1, 32'h5, WORD_MASK, 1'b0, 5'd6, 32'h11223344);
    issue(1'b1, 1'b0, 32'h5, WORD_MASK, 1'b0, 5'd8, 32'h0);
    drain();
`ifndef MISALIGN_TRAP_EN
    check("split_word_load", 128'(last_rsp), 128'(32'h11223344));
`endif
    issue(1'b0, 1'b1, 32'h7, HWORD_MASK, 1'b0, 5'd9, 32'h8001);
    issue(1'b1, 1'b0, 32'h7, HWORD_MASK, 1'b1, 5'd10, 32'h0);
    drain();
`ifndef MISALIGN_TRAP_EN
    check("split_hword_sext", 128'(last_rsp), 128'(32'hFFFF8001));
`endif
`ifdef MISALIGN_TRAP_EN
    issue(1'b1, 1'b0, 32'h2, WORD_MASK, 1'b0, 5'd7, 32'h0);
    drain();
    check("fault_tag", 128'(last_flt_tag), 128'(7));
`endif

    issue(1'b1, 1'b1, 32'h10, WORD_MASK, 1'b0, 5'd11, 32'h0);
    @(negedge clock);
    check("invalid_ready", 128'(bus.req_ready), 128'(1));
    issue(1'b0, 1'b0, 32'h10, WORD_MASK, 1'b0, 5'd12, 32'h0);
    @(negedge clock);
    check("none_ready", 128'(bus.req_ready), 128'(1));

    issue(1'b1, 1'b0, 32'h5, WORD_MASK, 1'b0, 5'd13, 32'h0);
    @(posedge clock);
    #2;
    reset_n = 1'b0;
    exp_ops.delete();  exp_rsp.delete();  exp_flt.delete();
    #1;
    check("midrst_mem_read", 128'(bus.mem_read), 128'(0));
    check("midrst_ready", 128'(bus.req_ready), 128'(1));
    repeat (3) @(negedge clock);
    reset_n = 1'b1;
    repeat (10) @(negedge clock);

    for (int t = 0; t < 300; t++) begin
      r = $urandom_range(0, 9);
      if (r == 0) begin
        rd = $urandom_range(0, 1) == 1;
        wr = rd;
      end else begin
        rd = r < 5;
        wr = !rd;
      end
      a = ($urandom_range(0, 7) == 0) ? 32'hFFFFFFFC + 32'($urandom_range(0, 3)) : 32'($urandom_range(0, 31));
      issue(rd, wr, a, lts[$urandom_range(0, 2)], 1'($urandom), 5'($urandom), $urandom);
    end
    drain();
    check("leftover", 128'(exp_ops.size() + exp_rsp.size() + exp_flt.size()), 128'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/mem_access_sequencer.md
Name: mem_access_sequencer

Overview:
- Sits between the execute/memory pipeline boundary and data_memory_top.
- Accepts one load/store request per handshake and drives data_memory_top's control, address and data inputs from registers.
- Aligned accesses pass through as a single memory operation.
- Misaligned accesses are split into serialized byte operations; load bytes are reassembled into a single response.

Parameters:
- ADDR_W, 32, width of req_addr and mem_long_addr.
- TAG_W, 5, width of the destination-register tag carried from request to response.

Ports:
- clock  in  1  rising-edge clock
- reset_n  in  1  asynchronous active-low reset
- req_valid  in  1  request present
- req_ready  out  1  sequencer can accept a request
- req_read  in  1  load request
- req_write  in  1  store request
- req_addr  in  ADDR_W  byte address
- req_wdata  in  32  store data, right-justified
- req_load_type  in  3  `byte_mask / `hword_mask / `word_mask
- req_sign_extend  in  1  sign-extend the load result
- req_tag  in  TAG_W  destination tag
- rsp_valid  out  1  load result valid, one-cycle pulse
- rsp_data  out  32  load result
- rsp_tag  out  TAG_W  tag of the returned load
- mem_read  out  1  to data_memory_top read
- mem_write  out  1  to data_memory_top write
- mem_long_addr  out  32  to data_memory_top long_addr
- mem_write_value  out  32  to data_memory_top write_value
- mem_load_type  out  3  to data_memory_top load_type
- mem_sign_extend  out  1  to data_memory_top sign_extend
- mem_read_value  in  32  from data_memory_top; valid in the cycle after mem_read

Behaviour:
- Reset (async, reset_n=0):
  - state=IDLE; req_ready=1.
  - rsp_valid, mem_read, mem_write, mem_sign_extend = 0.
  - All data/address outputs = 0.
  - Reset mid-operation abandons the access; no partial response is produced.
- Size: byte=1, hword=2, word=4. An access is misaligned when the address is not a multiple of its size.
- Accept: in IDLE, a handshake occurs when req_valid && req_ready. Latch all req_* fields.
- Invalid request: req_read==req_write (both or neither) is accepted and discarded, and the FSM stays in IDLE.
- States:
  - IDLE: req_ready=1, all memory strobes 0. On accept → ACCESS with idx=0 and n = aligned ? 1 : size.
  - ACCESS: req_ready=0. Drive element idx:
    - Aligned: the original type, address and sign_extend.
    - Split: `byte_mask, address addr+idx, mem_sign_extend=0, write_value = byte idx of req_wdata in bits [7:0] (little-endian).
    - Reads capture mem_read_value of element idx-1 into assembly byte lane idx-1.
    - idx++. When idx==n-1: load → COLLECT; store → IDLE.
  - COLLECT: strobes 0. Capture the final element.
    - Split loads: merge lanes, then sign-extend from bit 15 or 31 if req_sign_extend.
    - Aligned loads: take mem_read_value unchanged.
    - Go to RESP.
  - RESP: rsp_valid=1 for one cycle with rsp_data and rsp_tag; → IDLE.
- Latency, with accept at edge ending cycle N:
  - Aligned store: mem_write in cycle N+1.
  - Aligned load: mem_read in N+1, rsp_valid in N+3.
  - k-byte split load: rsp_valid in N+k+2.
- Throughput: req_ready is low from ACCESS through RESP, so there is no request overlap.
- Address wrap: addr+idx wraps modulo 2^ADDR_W.
- rsp_data and rsp_tag hold their last values when rsp_valid=0.

Optional Feature:
- MISALIGN_TRAP_EN defined:
  - Adds output misalign_fault (1 bit, reset 0).
  - A misaligned accepted request performs no memory access.
  - misalign_fault pulses in the cycle after accept (state FAULT), carrying rsp_tag; then → IDLE. rsp_valid stays 0.
- MISALIGN_TRAP_EN undefined: byte splitting as specified above; no misalign_fault port.

Decomposition:
- Shared definitions header already supplies the word/hword/byte types and the load_type mask macros.
- Add to the shared package:
  - the state enum (IDLE, ACCESS, COLLECT, RESP, FAULT);
  - a size_of(load_type) function;
  - a misaligned(addr, load_type) function.
- One sub-module, load_assembler: combinational lane merge plus sign/zero extension, parameterized on size.

Test Plan:
- Aligned word store 0xDEADBEEF at 0x10, then load → one mem_write cycle; load rsp_data=0xDEADBEEF exactly 3 cycles after accept.
- Byte store 0x80 at 0x3, then load with sign_extend=1 → rsp_data=0xFFFFFF80. Repeat with sign_extend=0 → 0x00000080.
- Word store 0x11223344 at 0x5 → 4 mem_write byte cycles at 0x5..0x8 with values 0x44,0x33,0x22,0x11. Word load at 0x5 → rsp_data=0x11223344 at N+6.
- Hword store 0x8001 at 0x7, then hword load with sign_extend=1 → two byte writes at 0x7 and 0x8; load rsp_data=0xFFFF8001.
- Request with read=write=1 → no mem strobes, no rsp_valid, req_ready stays 1. Then assert reset_n=0 mid split load → strobes drop immediately and no rsp_valid follows.
- With MISALIGN_TRAP_EN: word load at 0x2 with tag 7 → misalign_fault pulse with rsp_tag=7, zero memory strobes.
